// File: rtl/sid_wb_bridge.sv
// Bridge from SID transactor requests to an 8-bit Wishbone-style register slave.
// Requests are queued, issued one at a time with an ack timeout; irq edges are latched.
module sid_wb_bridge #(
    parameter int ADDR_WIDTH          = 8,
    parameter int DATA_WIDTH          = 8,
    parameter int REQ_FIFO_DEPTH      = 4,
    parameter int REQ_FIFO_ADDR_WIDTH = 2,
    parameter int NUM_IRQ             = 10,
    parameter int ACK_TIMEOUT         = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  we_o,
    output logic                  strobe_o,
    input  logic                  ack_i,
    input  logic [NUM_IRQ-1:0]    irq_i,
    input  logic [NUM_IRQ-1:0]    irq_mask_i,
    input  logic [NUM_IRQ-1:0]    irq_clr_i,
    output logic [NUM_IRQ-1:0]    irq_pending_o,
    output logic                  irq_o
);
    localparam int PW = REQ_FIFO_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t                  mem_q [REQ_FIFO_DEPTH];
    req_t                  head;
    logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  full, empty, push;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d, strobe_q, strobe_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [NUM_IRQ-1:0]    pend_q, pend_d, prev_q, prev_d;
    logic                  irq_q, irq_d;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = req_valid_i && !full;
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        strobe_d    = strobe_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (!empty) begin
                rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
                addr_d   = head.addr;
                wdata_d  = head.data;
                we_d     = head.we;
                strobe_d = 1'b1;
                cnt_d    = '0;
                state_d  = BUS;
            end
            BUS: begin
                // An ack arriving on the expiry cycle still completes normally.
                if (ack_i) begin
                    strobe_d    = 1'b0;
                    we_d        = 1'b0;
                    rsp_data_d  = we_q ? '0 : data_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
                    strobe_d    = 1'b0;
                    we_d        = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RSP: if (rsp_ready_i) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        prev_d = irq_i;
        pend_d = (pend_q & ~irq_clr_i) | (irq_i & ~prev_q);
        irq_d  = |(pend_q & irq_mask_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            strobe_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            pend_q      <= '0;
            prev_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            strobe_q    <= strobe_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            pend_q      <= pend_d;
            prev_q      <= prev_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= '{we: req_we_i, addr: req_addr_i, data: req_data_i};
    end

    assign req_ready_o   = !full;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_err_o     = rsp_err_q;
    assign address_o     = addr_q;
    assign data_o        = wdata_q;
    assign we_o          = we_q;
    assign strobe_o      = strobe_q;
    assign irq_pending_o = pend_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_sid_wb_bridge.sv
// Scoreboard bench for sid_wb_bridge: a register slave model answers strobes with a
// configurable ack delay and read data = addr ^ 0xD3; responses are checked in order.
module tb_sid_wb_bridge;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
    logic [7:0] req_addr_i = '0, req_data_i = '0;
    logic       rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
    logic [7:0] rsp_data_o, address_o, data_o, data_i = '0;
    logic       we_o, strobe_o, ack_i = 1'b0;
    logic [9:0] irq_i = '0, irq_mask_i = '0, irq_clr_i = '0, irq_pending_o;
    logic       irq_o;

    sid_wb_bridge #(.ACK_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .address_o(address_o), .data_o(data_o), .data_i(data_i),
        .we_o(we_o), .strobe_o(strobe_o), .ack_i(ack_i),
        .irq_i(irq_i), .irq_mask_i(irq_mask_i), .irq_clr_i(irq_clr_i),
        .irq_pending_o(irq_pending_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    int   ack_delay = 1;   // strobe cycle carrying ack; 0 = never ack
    bit   slave_en = 1'b1;
    logic ack_man = 1'b0;
    int   str_cnt = 0, last_len = 0, n_strobe = 0, n_rsp = 0;

    // Slave model: updates on the falling edge, away from the DUT sampling edge.
    always @(negedge clk) begin
        data_i = address_o ^ 8'hD3;
        if (strobe_o) begin
            str_cnt++;
            if (str_cnt == 1) n_strobe++;
            ack_i = slave_en ? (ack_delay != 0 && str_cnt == ack_delay) : ack_man;
        end else begin
            if (str_cnt != 0) last_len = str_cnt;
            str_cnt = 0;
            ack_i = slave_en ? 1'b0 : ack_man;
        end
    end

    // Response monitor: pop the oldest expectation on every handshake.
    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            exp_t e;
            n_chk++;
            n_rsp++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected: got data=%h err=%b, required no response", rsp_data_o, rsp_err_o);
            end else begin
                e = sb.pop_front();
                if (rsp_data_o !== e.data || rsp_err_o !== e.err)
                    $display("FAIL rsp: got data=%h err=%b, required data=%h err=%b",
                             rsp_data_o, rsp_err_o, e.data, e.err);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        bit   ok = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_data_i  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready_o;
            tick();
        end
        req_valid_i = 1'b0;
        if (ok) begin
            e.err  = slave_en && (ack_delay == 0 || ack_delay > TO);
            e.data = (e.err || we) ? 8'h00 : (a ^ 8'hD3);
            sb.push_back(e);
        end else begin
            n_chk++;
            $display("FAIL push_timeout: got req_ready_o=0 for 100 cycles, required 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        n_chk++;
        if (sb.size() != 0) $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        n_chk++;
        if ({req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, strobe_o, we_o, address_o, data_o} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00})
            $display("FAIL reset_bus: got rdy=%b vld=%b d=%h e=%b stb=%b we=%b a=%h wd=%h, required 1 0 00 0 0 0 00 00",
                     req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, strobe_o, we_o, address_o, data_o);
        else n_pass++;
        n_chk++;
        if (irq_pending_o !== 10'h0 || irq_o !== 1'b0)
            $display("FAIL reset_irq: got pend=%h irq=%b, required 000 0", irq_pending_o, irq_o);
        else n_pass++;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_write();
        ack_delay   = 2;
        rsp_ready_i = 1'b1;
        push(1'b1, 8'h03, 8'h5A);
        n_chk++;
        if (strobe_o !== 1'b0) $display("FAIL wr_latency: got strobe_o=%b, required 0", strobe_o);
        else n_pass++;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_chk++;
            if ({strobe_o, we_o, address_o, data_o} !== {1'b1, 1'b1, 8'h03, 8'h5A})
                $display("FAIL wr_bus_c%0d: got stb=%b we=%b a=%h d=%h, required 1 1 03 5a", c, strobe_o, we_o, address_o, data_o);
            else n_pass++;
        end
        tick();
        n_chk++;
        if (strobe_o !== 1'b0 || we_o !== 1'b0) $display("FAIL wr_end: got stb=%b we=%b, required 0 0", strobe_o, we_o);
        else n_pass++;
        drain();
        n_chk++;
        if (last_len !== 2) $display("FAIL wr_len: got %0d strobe cycles, required 2", last_len);
        else n_pass++;
    endtask

    task automatic test_read();
        ack_delay = 1;
        push(1'b0, 8'h10, 8'h00);
        tick();
        n_chk++;
        if ({strobe_o, we_o, address_o} !== {1'b1, 1'b0, 8'h10})
            $display("FAIL rd_bus: got stb=%b we=%b a=%h, required 1 0 10", strobe_o, we_o, address_o);
        else n_pass++;
        tick();
        n_chk++;
        if ({strobe_o, rsp_valid_o, rsp_data_o, rsp_err_o} !== {1'b0, 1'b1, 8'hC3, 1'b0})
            $display("FAIL rd_rsp: got stb=%b vld=%b d=%h e=%b, required 0 1 c3 0", strobe_o, rsp_valid_o, rsp_data_o, rsp_err_o);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        int base_s = n_strobe, base_r = n_rsp;
        ack_delay   = 1;
        rsp_ready_i = 1'b0;
        push(1'b1, 8'h30, 8'hA1);
        push(1'b0, 8'h31, 8'h00);
        push(1'b1, 8'h32, 8'hA3);
        push(1'b0, 8'h33, 8'h00);
        n_chk++;
        if (req_ready_o !== 1'b1) $display("FAIL b2b_ready4: got %b, required 1", req_ready_o);
        else n_pass++;
        push(1'b0, 8'h34, 8'h00);
        n_chk++;
        if (req_ready_o !== 1'b0) $display("FAIL b2b_ready5: got %b, required 0", req_ready_o);
        else n_pass++;
        repeat (10) tick();
        n_chk++;
        if (rsp_valid_o !== 1'b1 || n_strobe - base_s != 1)
            $display("FAIL b2b_stall: got vld=%b strobes=%0d, required 1 1", rsp_valid_o, n_strobe - base_s);
        else n_pass++;
        rsp_ready_i = 1'b1;
        drain();
        n_chk++;
        if (n_strobe - base_s != 5 || n_rsp - base_r != 5)
            $display("FAIL b2b_count: got strobes=%0d rsps=%0d, required 5 5", n_strobe - base_s, n_rsp - base_r);
        else n_pass++;
    endtask

    task automatic test_timeout();
        rsp_ready_i = 1'b1;
        ack_delay   = 0;
        push(1'b0, 8'h20, 8'h00);
        drain();
        n_chk++;
        if (last_len !== TO) $display("FAIL to_len: got %0d strobe cycles, required %0d", last_len, TO);
        else n_pass++;
        ack_delay = TO;
        push(1'b0, 8'h21, 8'h00);
        drain();
        n_chk++;
        if (last_len !== TO) $display("FAIL to_late_ack_len: got %0d strobe cycles, required %0d", last_len, TO);
        else n_pass++;
    endtask

    task automatic test_irq();
        irq_mask_i = 10'h004;
        irq_i[2] = 1'b1;
        tick();
        irq_i[2] = 1'b0;
        n_chk++;
        if (irq_pending_o !== 10'h004 || irq_o !== 1'b0)
            $display("FAIL irq_set: got pend=%h irq=%b, required 004 0", irq_pending_o, irq_o);
        else n_pass++;
        tick();
        n_chk++;
        if (irq_o !== 1'b1) $display("FAIL irq_lag: got irq_o=%b, required 1", irq_o);
        else n_pass++;
        irq_i[2] = 1'b1;
        irq_clr_i[2] = 1'b1;
        tick();
        n_chk++;
        if (irq_pending_o !== 10'h004) $display("FAIL irq_set_wins: got pend=%h, required 004", irq_pending_o);
        else n_pass++;
        irq_i[2] = 1'b0;
        tick();
        irq_clr_i[2] = 1'b0;
        n_chk++;
        if (irq_pending_o !== 10'h000 || irq_o !== 1'b1)
            $display("FAIL irq_clr: got pend=%h irq=%b, required 000 1", irq_pending_o, irq_o);
        else n_pass++;
        tick();
        n_chk++;
        if (irq_o !== 1'b0) $display("FAIL irq_clr_lag: got irq_o=%b, required 0", irq_o);
        else n_pass++;
        irq_i[5] = 1'b1;
        tick();
        irq_i[5] = 1'b0;
        tick();
        tick();
        n_chk++;
        if (irq_pending_o !== 10'h020 || irq_o !== 1'b0)
            $display("FAIL irq_masked: got pend=%h irq=%b, required 020 0", irq_pending_o, irq_o);
        else n_pass++;
        irq_mask_i = 10'h020;
        tick();
        n_chk++;
        if (irq_o !== 1'b1) $display("FAIL irq_unmask: got irq_o=%b, required 1", irq_o);
        else n_pass++;
        irq_clr_i = 10'h020;
        tick();
        irq_clr_i = '0;
        tick();
        n_chk++;
        if (irq_pending_o !== 10'h000 || irq_o !== 1'b0)
            $display("FAIL irq_clr5: got pend=%h irq=%b, required 000 0", irq_pending_o, irq_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        slave_en    = 1'b0;
        ack_man     = 1'b0;
        rsp_ready_i = 1'b0;
        push(1'b1, 8'h40, 8'h11);
        push(1'b0, 8'h41, 8'h00);
        n_chk++;
        if (strobe_o !== 1'b1) $display("FAIL rm_strobe: got %b, required 1", strobe_o);
        else n_pass++;
        rst_i    = 1'b1;
        irq_i[0] = 1'b1;
        tick();
        sb.delete();
        n_chk++;
        if (strobe_o !== 1'b0 || req_ready_o !== 1'b1 || irq_pending_o !== 10'h000)
            $display("FAIL rm_reset: got stb=%b rdy=%b pend=%h, required 0 1 000", strobe_o, req_ready_o, irq_pending_o);
        else n_pass++;
        rst_i   = 1'b0;
        ack_man = 1'b1;
        tick();
        n_chk++;
        if (irq_pending_o !== 10'h001) $display("FAIL rm_irq_release: got pend=%h, required 001", irq_pending_o);
        else n_pass++;
        irq_clr_i[0] = 1'b1;
        tick();
        irq_clr_i[0] = 1'b0;
        ack_man = 1'b0;
        repeat (4) tick();
        n_chk++;
        if (rsp_valid_o !== 1'b0 || strobe_o !== 1'b0 || req_ready_o !== 1'b1 || irq_pending_o !== 10'h000)
            $display("FAIL rm_after: got vld=%b stb=%b rdy=%b pend=%h, required 0 0 1 000",
                     rsp_valid_o, strobe_o, req_ready_o, irq_pending_o);
        else n_pass++;
        irq_i[0] = 1'b0;
        slave_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_irq();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
